// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: issues a burst of wide reads at consecutive word addresses
// to the scratchpad RAM, buffers the returned words in a small FIFO and
// presents them on a valid/ready stream. Reads are issued only when the FIFO
// has room for the word plus any read still in flight, so backpressure never
// overflows the buffer and ready_i has no combinational path to the RAM port.
module ram_rd_streamer #(
   parameter int addrWidth      = 32,
   parameter int dataSize       = 8,
   parameter int interfaceWidth = 256,
   parameter int lenWidth       = 16,
   parameter int bufDepth       = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [addrWidth-1:0]      base_addr_i,
   input  logic [lenWidth-1:0]       len_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      rd_en_o,
   output logic [addrWidth-1:0]      rd_addr_o,
   input  logic [interfaceWidth-1:0] rd_data_i,
   output logic [interfaceWidth-1:0] data_o,
   output logic                      valid_o,
   input  logic                      ready_i
);

   localparam int PTR_W = $clog2(bufDepth);
   localparam int CNT_W = $clog2(bufDepth + 1);

   // Byte stride between consecutive wide words.
   localparam logic [addrWidth-1:0] STRIDE   = addrWidth'(interfaceWidth / dataSize);
   localparam logic [CNT_W:0]       DEPTH    = (CNT_W + 1)'(bufDepth);
   localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(bufDepth - 1);
   localparam logic [lenWidth-1:0]  LEN_ONE  = lenWidth'(1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nxt;

   // Burst bookkeeping.
   logic [addrWidth-1:0] addr_q;       // next address to issue
   logic [lenWidth-1:0]  len_q;
   logic [lenWidth-1:0]  issued_q;
   logic [lenWidth-1:0]  accepted_q;
   logic                 inflight_q;   // a read issued last cycle returns now

   // Output FIFO.
   logic [interfaceWidth-1:0] mem [bufDepth];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          fifo_count;

   logic           push;
   logic           pop;
   logic           fifo_empty;
   logic           last_pop;
   logic [CNT_W:0] occupancy;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign push       = inflight_q;
   assign fifo_empty = (fifo_count == '0);
   assign pop        = !fifo_empty && ready_i;
   assign last_pop   = pop && ((accepted_q + LEN_ONE) == len_q);
   // Words already buffered plus the one on its way back from the RAM.
   assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

   assign rd_addr_o = addr_q;
   assign valid_o   = !fifo_empty;
   // Gated so the stream data reads as zero whenever nothing is buffered.
   assign data_o    = fifo_empty ? '0 : mem[rd_ptr];

   // FSM state register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: assigning a default first guarantees every path drives the
      // signal, so no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
         RUN:     if (last_pop) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: status flags and the credit-based read issue.
   always_comb begin
      busy_o  = 1'b0;
      done_o  = 1'b0;
      rd_en_o = 1'b0;
      case (state)
         RUN: begin
            busy_o  = 1'b1;
            rd_en_o = (issued_q < len_q) && (occupancy < DEPTH);
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Command latch, issue/accept counters, address generator, in-flight flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_en_o;
         if (state == IDLE && start_i) begin
            addr_q     <= base_addr_i;
            len_q      <= len_i;
            issued_q   <= '0;
            accepted_q <= '0;
         end else begin
            if (rd_en_o) begin
               addr_q   <= addr_q + STRIDE;  // wraps modulo 2^addrWidth
               issued_q <= issued_q + LEN_ONE;
            end
            if (pop) accepted_q <= accepted_q + LEN_ONE;
         end
      end
   end

   // FIFO pointers and fill count; push and pop may coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage: capture the RAM response the cycle after each read.
   // NOTE: the storage array is deliberately not reset; the pointers and
   // count define which entries are meaningful and data_o is gated when empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rd_data_i;
   end

endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
Read-side initiator for the wide port of the team's multi-port byte-addressed scratchpad RAM, which has a registered, single-cycle read response. On a start command it issues a burst of wide reads at consecutive word addresses. It buffers the returned words and presents them on a valid/ready stream toward the compute array. It tolerates arbitrary downstream backpressure without losing or duplicating words.

Parameters:
addrWidth, 32, RAM byte-address width
dataSize, 8, bits per RAM element (byte)
interfaceWidth, 256, width of RAM read data and of the output stream
lenWidth, 16, width of the burst length (in wide words)
bufDepth, 3, output buffer entries; must be at least 3 for full throughput

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start_i  in  1  start pulse; sampled only in IDLE
base_addr_i  in  addrWidth  first byte address of the burst
len_i  in  lenWidth  number of wide words to read
busy_o  out  1  high from the accepted start until the done cycle, inclusive
done_o  out  1  one-cycle pulse when the last word is accepted downstream
rd_en_o  out  1  RAM read enable
rd_addr_o  out  addrWidth  RAM read byte address
rd_data_i  in  interfaceWidth  RAM read data, valid on the cycle after rd_en_o
data_o  out  interfaceWidth  stream data, the RAM word unmodified
valid_o  out  1  stream valid
ready_i  in  1  stream ready

Behaviour:
- Reset: async on rst high. State = IDLE, FIFO empty, inflight = 0. All outputs are 0: busy_o, done_o, rd_en_o, rd_addr_o, data_o, valid_o.
- Stride: NB = interfaceWidth/dataSize bytes. The k-th read address is base + k*NB, taken modulo 2^addrWidth (wraps silently). No alignment check is made.
- FSM states are IDLE, RUN and DONE.
  - IDLE: when start_i is high, latch base_addr_i and len_i, clear the issue and accept counters, then go to RUN. If len_i == 0, go to DONE instead.
  - RUN: leave for DONE on the cycle the accepted count reaches len.
  - DONE: done_o = 1 and busy_o = 1 for exactly one cycle, then IDLE.
- A start_i seen outside IDLE is ignored. It has no effect on the running burst.
- Issue rule in RUN: rd_en_o = (issued < len) && (fifo_count + inflight < bufDepth). The rule is registered-state only, with no combinational path from ready_i. The issue counter and address advance on each rd_en_o.
- inflight is a register set to rd_en_o on every clock.
- When inflight is 1, rd_data_i is written into the FIFO tail that cycle. The credit rule guarantees the FIFO never overflows.
- Output:
  - valid_o = fifo not empty, and data_o = FIFO head.
  - A pop occurs on valid_o && ready_i, and increments the accepted count.
  - A simultaneous push and pop in the same cycle is legal; the count is unchanged.
  - data_o holds stable while valid_o && !ready_i.
- Latency: start edge at cycle 0, then rd_en_o in cycle 1, data returned in cycle 2, valid_o in cycle 3.
- Throughput: one word per cycle with ready_i held high and bufDepth ≥ 3.
- When rd_en_o = 0, rd_addr_o holds the next address to be issued.
- Reset mid-burst aborts immediately: the FIFO is flushed, any in-flight read is discarded, and done_o does not pulse.

Test Plan:
- Basic burst: base=0x40, len=4, ready_i=1 -> rd_addr_o = 0x40, 0x60, 0x80, 0xA0 on cycles 1-4. valid_o on cycles 3-6 carries the RAM words in address order. done_o pulses on cycle 7, and busy_o falls on cycle 8.
- Backpressure: len=6, ready_i toggling 1,0,0,1,... and held low for 5 cycles:
  - No more than 3 words are buffered, and rd_en_o stays low while full.
  - All 6 words arrive in order with no duplicates, and data_o is stable while stalled.
- Zero length: start with len=0 -> rd_en_o is never asserted, valid_o stays 0, and done_o pulses on cycle 1.
- Address wrap with addrWidth=8: base=0xE0, len=3 -> addresses 0xE0, 0x00, 0x20.
- Start while busy: a second start_i with a different base mid-burst is ignored. The address sequence and length match the first command only.
- Reset mid-burst: assert rst while 2 words are buffered -> all outputs are 0 immediately. A subsequent start with base=0x0, len=2 completes normally with exactly 2 words.
